// File: rtl/carfield_apb_periph_demux_if.sv
// APB bundle seen by the peripheral demux: one upstream requester port and
// NumSlv downstream completer ports sharing a single request bus.
interface carfield_apb_periph_demux_if #(
    parameter int unsigned NumSlv = 6
);
    // Upstream request / response
    logic [31:0]              s_paddr_i;
    logic                     s_psel_i;
    logic                     s_penable_i;
    logic                     s_pwrite_i;
    logic [31:0]              s_pwdata_i;
    logic [3:0]               s_pstrb_i;
    logic [2:0]               s_pprot_i;
    logic [31:0]              s_prdata_o;
    logic                     s_pready_o;
    logic                     s_pslverr_o;

    // Downstream shared request, per-port response
    logic [NumSlv-1:0]        m_psel_o;
    logic [31:0]              m_paddr_o;
    logic                     m_penable_o;
    logic                     m_pwrite_o;
    logic [31:0]              m_pwdata_o;
    logic [3:0]               m_pstrb_o;
    logic [2:0]               m_pprot_o;
    logic [NumSlv-1:0][31:0]  m_prdata_i;
    logic [NumSlv-1:0]        m_pready_i;
    logic [NumSlv-1:0]        m_pslverr_i;

    // Demux side
    modport slave (
        input  s_paddr_i, s_psel_i, s_penable_i, s_pwrite_i, s_pwdata_i, s_pstrb_i, s_pprot_i,
        output s_prdata_o, s_pready_o, s_pslverr_o,
        output m_psel_o, m_paddr_o, m_penable_o, m_pwrite_o, m_pwdata_o, m_pstrb_o, m_pprot_o,
        input  m_prdata_i, m_pready_i, m_pslverr_i
    );

    // Environment side: upstream requester plus downstream completers
    modport master (
        output s_paddr_i, s_psel_i, s_penable_i, s_pwrite_i, s_pwdata_i, s_pstrb_i, s_pprot_i,
        input  s_prdata_o, s_pready_o, s_pslverr_o,
        input  m_psel_o, m_paddr_o, m_penable_o, m_pwrite_o, m_pwdata_o, m_pstrb_o, m_pprot_o,
        output m_prdata_i, m_pready_i, m_pslverr_i
    );
endinterface

// File: rtl/carfield_apb_periph_demux.sv
// Registered APB 1:N demux with address decode, access timeout and error capture.
// Every upstream transfer is re-issued downstream from captured request fields.
module carfield_apb_periph_demux #(
    parameter int unsigned NumSlv                 = 6,
    parameter logic [31:0] SlvBase [NumSlv]       = '{32'h2000_1000, 32'h2000_4000,
                                                      32'h2000_5000, 32'h2000_7000,
                                                      32'h2000_8000, 32'h2001_1000},
    parameter logic [31:0] SlvSize [NumSlv]       = '{32'h0000_1000, 32'h0000_1000,
                                                      32'h0000_1000, 32'h0000_1000,
                                                      32'h0000_1000, 32'h0000_8000},
    parameter int unsigned TimeoutCycles          = 256
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    carfield_apb_periph_demux_if.slave        bus,
    output logic                              timeout_irq_o,
    output logic [31:0]                       err_addr_o
);

    localparam int unsigned IdxW        = (NumSlv > 1) ? $clog2(NumSlv) : 1;
    localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StMSetup  = 2'd1;
    localparam logic [1:0] StMAccess = 2'd2;
    localparam logic [1:0] StResp    = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_d;
    logic [31:0]       r_addr;
    logic              r_write;
    logic [31:0]       r_wdata;
    logic [3:0]        r_strb;
    logic [2:0]        r_prot;
    logic [IdxW-1:0]   r_idx;
    logic [15:0]       r_cnt;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic              r_timeout_irq;
    logic [31:0]       r_err_addr;

    logic [NumSlv-1:0] w_region_hit;
    logic              w_hit;
    logic [IdxW-1:0]   w_idx;
    logic              w_setup;
    logic              w_ready;
    logic              w_cnt_last;
    logic              w_resp;
    logic [NumSlv-1:0] w_psel;

    // Region end is formed at 33 bits so a region touching 4 GiB cannot wrap.
    for (genvar g = 0; g < NumSlv; g++) begin : g_decode
        logic [32:0] w_end;
        assign w_end           = {1'b0, SlvBase[g]} + {1'b0, SlvSize[g]};
        assign w_region_hit[g] = (SlvSize[g] != 32'h0) &&
                                 (bus.s_paddr_i >= SlvBase[g]) &&
                                 ({1'b0, bus.s_paddr_i} < w_end);
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = int'(NumSlv) - 1; i >= 0; i--) begin
            if (w_region_hit[i]) begin
                w_hit = 1'b1;
                w_idx = IdxW'(i);
            end
        end
    end

    assign w_setup    = (r_state == StIdle) && bus.s_psel_i && !bus.s_penable_i;
    assign w_ready    = bus.m_pready_i[r_idx];
    assign w_cnt_last = (r_cnt == TimeoutLast);

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (w_setup) begin
                    w_state_d = w_hit ? StMSetup : StResp;
                end
            end
            StMSetup:  w_state_d = StMAccess;
            StMAccess: begin
                if (w_ready || w_cnt_last) begin
                    w_state_d = StResp;
                end
            end
            StResp:    w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= StIdle;
            r_addr        <= '0;
            r_write       <= 1'b0;
            r_wdata       <= '0;
            r_strb        <= '0;
            r_prot        <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_rdata       <= '0;
            r_err         <= 1'b0;
            r_timeout_irq <= 1'b0;
            r_err_addr    <= '0;
        end else begin
            r_state       <= w_state_d;
            r_timeout_irq <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_setup) begin
                        r_addr  <= bus.s_paddr_i;
                        r_write <= bus.s_pwrite_i;
                        r_wdata <= bus.s_pwdata_i;
                        r_strb  <= bus.s_pstrb_i;
                        r_prot  <= bus.s_pprot_i;
                        r_idx   <= w_idx;
                        r_cnt   <= '0;
                        r_rdata <= '0;
                        r_err   <= !w_hit;
                        if (!w_hit) begin
                            r_err_addr <= bus.s_paddr_i;
                        end
                    end
                end
                StMAccess: begin
                    if (w_ready) begin
                        r_rdata <= r_write ? 32'h0 : bus.m_prdata_i[r_idx];
                        r_err   <= bus.m_pslverr_i[r_idx];
                        if (bus.m_pslverr_i[r_idx]) begin
                            r_err_addr <= r_addr;
                        end
                    end else if (w_cnt_last) begin
                        r_rdata       <= '0;
                        r_err         <= 1'b1;
                        r_timeout_irq <= 1'b1;
                        r_err_addr    <= r_addr;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // An upstream that has already dropped psel gets no response at all.
    assign w_resp = (r_state == StResp) && bus.s_psel_i;

    always_comb begin
        w_psel = '0;
        if ((r_state == StMSetup) || (r_state == StMAccess)) begin
            w_psel[r_idx] = 1'b1;
        end
    end

    assign bus.s_pready_o  = w_resp;
    assign bus.s_prdata_o  = w_resp ? r_rdata : 32'h0;
    assign bus.s_pslverr_o = w_resp ? r_err : 1'b0;

    assign bus.m_psel_o    = w_psel;
    assign bus.m_penable_o = (r_state == StMAccess);
    assign bus.m_paddr_o   = r_addr;
    assign bus.m_pwrite_o  = r_write;
    assign bus.m_pwdata_o  = r_wdata;
    assign bus.m_pstrb_o   = r_strb;
    assign bus.m_pprot_o   = r_prot;

    assign timeout_irq_o   = r_timeout_irq;
    assign err_addr_o      = r_err_addr;

    a_psel_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.m_psel_o));
    a_pready_in_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.s_pready_o |-> (r_state == StResp));
    a_penable_needs_psel: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.m_penable_o |-> (bus.m_psel_o != '0));

endmodule

// File: tb/tb_carfield_apb_periph_demux.sv
// Scoreboard bench for carfield_apb_periph_demux: one requester, six modelled completers.
module tb_carfield_apb_periph_demux;

    localparam int unsigned NumSlv = 6;
    localparam int unsigned Tmo    = 16;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b0;
    logic        timeout_irq_o;
    logic [31:0] err_addr_o;

    always #5 clk_i = ~clk_i;

    carfield_apb_periph_demux_if #(.NumSlv(NumSlv)) bus ();

    carfield_apb_periph_demux #(
        .NumSlv        (NumSlv),
        .SlvSize       ('{32'h1000, 32'h0, 32'h1000, 32'h1000, 32'h1000, 32'h8000}),
        .TimeoutCycles (Tmo)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .bus           (bus),
        .timeout_irq_o (timeout_irq_o),
        .err_addr_o    (err_addr_o)
    );

    // Completer model: per-port wait states, stall, read data and error
    int unsigned       ws [NumSlv];
    logic [31:0]       rd [NumSlv];
    logic [NumSlv-1:0] stall;
    logic [NumSlv-1:0] serr;
    int unsigned       wcnt;

    always_ff @(posedge clk_i) wcnt <= bus.m_penable_o ? wcnt + 1 : 0;

    always_comb begin
        for (int i = 0; i < NumSlv; i++) begin
            bus.m_pready_i[i]  = bus.m_psel_o[i] && bus.m_penable_o && !stall[i] && (wcnt >= ws[i]);
            bus.m_prdata_i[i]  = rd[i];
            bus.m_pslverr_i[i] = serr[i];
        end
    end

    int unsigned cyc;
    int unsigned irq_cnt;
    int unsigned irq_run;
    int unsigned irq_run_max;

    always_ff @(posedge clk_i) cyc <= cyc + 1;

    always_ff @(negedge clk_i) begin
        if (timeout_irq_o) begin
            irq_cnt <= irq_cnt + 1;
            irq_run <= irq_run + 1;
            if (irq_run + 1 > irq_run_max) irq_run_max <= irq_run + 1;
        end else begin
            irq_run <= 0;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned lat;
    } exp_t;

    typedef struct {
        logic [31:0]              rdata;
        logic                     err;
        int unsigned              lat;
        logic                     done;
        logic [31:0][NumSlv-1:0]  psel_tr;
        logic [31:0]              pen_tr;
        logic [NumSlv-1:0]        psel_or;
        logic                     hold_bad;
        int unsigned              resp_cyc;
    } obs_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Bus-functional requester: drives one transfer and records what it sees.
    // lat counts cycles after the setup cycle up to the one with s_pready_o.
    task automatic apb_do(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          output obs_t o);
        o.rdata = '0; o.err = 1'b0; o.lat = 1; o.done = 1'b0; o.psel_tr = '0; o.pen_tr = '0;
        o.psel_or = '0; o.hold_bad = 1'b0; o.resp_cyc = 0;
        bus.s_paddr_i  = addr;
        bus.s_pwrite_i = wr;
        bus.s_pwdata_i = wdata;
        bus.s_pstrb_i  = 4'hF;
        bus.s_pprot_i  = 3'b010;
        bus.s_psel_i   = 1'b1;
        bus.s_penable_i = 1'b0;
        @(posedge clk_i); #1;
        bus.s_penable_i = 1'b1;
        while (!o.done && o.lat < 40) begin
            @(negedge clk_i);
            if (o.lat < 32) begin
                o.psel_tr[5'(o.lat)] = bus.m_psel_o;
                o.pen_tr[5'(o.lat)]  = bus.m_penable_o;
            end
            o.psel_or = o.psel_or | bus.m_psel_o;
            if (bus.m_psel_o != '0 && (bus.m_paddr_o !== addr || bus.m_pwrite_o !== wr ||
                bus.m_pwdata_o !== wdata || bus.m_pstrb_o !== 4'hF || bus.m_pprot_o !== 3'b010))
                o.hold_bad = 1'b1;
            if (bus.s_pready_o) begin
                o.done     = 1'b1;
                o.rdata    = bus.s_prdata_o;
                o.err      = bus.s_pslverr_o;
                o.resp_cyc = cyc;
            end else begin
                @(posedge clk_i); #1;
                o.lat++;
            end
        end
        @(posedge clk_i); #1;
        bus.s_psel_i    = 1'b0;
        bus.s_penable_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        n_chk++; if (bus.s_pready_o !== 1'b0 || bus.m_psel_o !== '0 || bus.m_penable_o !== 1'b0) begin
            n_err++; $display("FAIL reset_hs: pready=%b psel=%b penable=%b, want 0", bus.s_pready_o,
                              bus.m_psel_o, bus.m_penable_o); end
        n_chk++; if (err_addr_o !== 32'h0 || timeout_irq_o !== 1'b0) begin
            n_err++; $display("FAIL reset_err: err_addr=%h irq=%b, want 0", err_addr_o, timeout_irq_o); end
        n_chk++; if (bus.m_paddr_o !== 32'h0 || bus.s_prdata_o !== 32'h0) begin
            n_err++; $display("FAIL reset_data: paddr=%h prdata=%h, want 0", bus.m_paddr_o,
                              bus.s_prdata_o); end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_chk++; if (bus.s_pready_o !== 1'b0 || bus.m_psel_o !== '0) begin
            n_err++; $display("FAIL reset_release: pready=%b psel=%b, want 0", bus.s_pready_o,
                              bus.m_psel_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_write_hit();
        obs_t o; exp_t e;
        sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 3});
        apb_do(32'h2000_1010, 1'b1, 32'hA5A5_A5A5, o);
        e = sb.pop_front();
        n_chk++; if (!o.done || o.lat !== e.lat) begin
            n_err++; $display("FAIL wr_latency: done=%b got %0d, want %0d", o.done, o.lat, e.lat); end
        n_chk++; if (o.err !== e.err || o.rdata !== e.rdata) begin
            n_err++; $display("FAIL wr_resp: err=%b rdata=%h, want %b %h", o.err, o.rdata, e.err,
                              e.rdata); end
        n_chk++; if (o.psel_tr[1] !== 6'b000001 || o.pen_tr[1] !== 1'b0) begin
            n_err++; $display("FAIL wr_setup: psel=%b pen=%b, want 000001 0", o.psel_tr[1],
                              o.pen_tr[1]); end
        n_chk++; if (o.psel_tr[2] !== 6'b000001 || o.pen_tr[2] !== 1'b1) begin
            n_err++; $display("FAIL wr_access: psel=%b pen=%b, want 000001 1", o.psel_tr[2],
                              o.pen_tr[2]); end
        n_chk++; if (o.hold_bad !== 1'b0) begin
            n_err++; $display("FAIL wr_hold: request fields changed=%b, want 0", o.hold_bad); end
    endtask

    task automatic test_read_wait();
        obs_t o; exp_t e;
        ws[5] = 3; rd[5] = 32'h1234_5678;
        sb.push_back('{rdata: 32'h1234_5678, err: 1'b0, lat: 6});
        apb_do(32'h2001_8FFC, 1'b0, 32'h0, o);
        e = sb.pop_front();
        n_chk++; if (!o.done || o.lat !== e.lat) begin
            n_err++; $display("FAIL rd_latency: done=%b got %0d, want %0d", o.done, o.lat, e.lat); end
        n_chk++; if (o.rdata !== e.rdata || o.err !== e.err) begin
            n_err++; $display("FAIL rd_data: rdata=%h err=%b, want %h %b", o.rdata, o.err, e.rdata,
                              e.err); end
        n_chk++; if (o.psel_tr[4] !== 6'b100000 || o.pen_tr[5] !== 1'b1 || o.psel_tr[6] !== '0) begin
            n_err++; $display("FAIL rd_strobes: psel4=%b pen5=%b psel6=%b", o.psel_tr[4], o.pen_tr[5],
                              o.psel_tr[6]); end
        n_chk++; if (o.hold_bad !== 1'b0) begin
            n_err++; $display("FAIL rd_hold: request fields changed=%b, want 0", o.hold_bad); end
        ws[5] = 0;
    endtask

    task automatic test_miss();
        obs_t o; exp_t e;
        sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
        apb_do(32'h2001_9000, 1'b0, 32'h0, o);
        e = sb.pop_front();
        n_chk++; if (!o.done || o.lat !== e.lat || o.err !== e.err || o.rdata !== e.rdata) begin
            n_err++; $display("FAIL miss_resp: lat=%0d err=%b rdata=%h, want %0d %b %h", o.lat, o.err,
                              o.rdata, e.lat, e.err, e.rdata); end
        n_chk++; if (o.psel_or !== '0) begin
            n_err++; $display("FAIL miss_psel: saw psel=%b, want 000000", o.psel_or); end
        n_chk++; if (err_addr_o !== 32'h2001_9000) begin
            n_err++; $display("FAIL miss_err_addr: got %h, want 20019000", err_addr_o); end
    endtask

    task automatic test_decode_boundary();
        logic [31:0]       addrs [5] = '{32'h2000_0FFC, 32'h2000_1FFC, 32'h2000_2000,
                                         32'h2000_7FFC, 32'h2001_1000};
        logic [NumSlv-1:0] sels  [5] = '{6'b000000, 6'b000001, 6'b000000, 6'b001000, 6'b100000};
        obs_t o; exp_t e;
        for (int k = 0; k < 5; k++) begin
            if (sels[k] == '0) sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
            else sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 3});
            apb_do(addrs[k], 1'b1, 32'h0BAD_F00D + k, o);
            e = sb.pop_front();
            n_chk++; if (!o.done || o.lat !== e.lat || o.err !== e.err || o.psel_or !== sels[k]) begin
                n_err++; $display("FAIL decode %h: lat=%0d err=%b psel=%b, want %0d %b %b", addrs[k],
                                  o.lat, o.err, o.psel_or, e.lat, e.err, sels[k]); end
        end
    endtask

    task automatic test_slverr();
        obs_t o; exp_t e; int unsigned irq0;
        irq0 = irq_cnt; serr[2] = 1'b1; rd[2] = 32'hCAFE_0002;
        sb.push_back('{rdata: 32'hCAFE_0002, err: 1'b1, lat: 3});
        apb_do(32'h2000_5004, 1'b0, 32'h0, o);
        e = sb.pop_front();
        n_chk++; if (!o.done || o.lat !== e.lat || o.err !== e.err || o.rdata !== e.rdata) begin
            n_err++; $display("FAIL slverr_resp: lat=%0d err=%b rdata=%h, want %0d %b %h", o.lat,
                              o.err, o.rdata, e.lat, e.err, e.rdata); end
        n_chk++; if (err_addr_o !== 32'h2000_5004) begin
            n_err++; $display("FAIL slverr_err_addr: got %h, want 20005004", err_addr_o); end
        n_chk++; if (irq_cnt - irq0 !== 0) begin
            n_err++; $display("FAIL slverr_irq: %0d pulses, want 0", irq_cnt - irq0); end
        serr[2] = 1'b0;
    endtask

    task automatic test_timeout();
        obs_t o; exp_t e; int unsigned irq0;
        irq0 = irq_cnt; stall[3] = 1'b1;
        sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 2 + Tmo});
        apb_do(32'h2000_7000, 1'b0, 32'h0, o);
        e = sb.pop_front();
        @(posedge clk_i); #1;
        n_chk++; if (!o.done || o.lat !== e.lat || o.err !== e.err || o.rdata !== e.rdata) begin
            n_err++; $display("FAIL tmo_resp: lat=%0d err=%b rdata=%h, want %0d %b %h", o.lat, o.err,
                              o.rdata, e.lat, e.err, e.rdata); end
        n_chk++; if (o.psel_tr[1 + Tmo] !== 6'b001000 || o.pen_tr[1 + Tmo] !== 1'b1 ||
                     o.psel_tr[2 + Tmo] !== '0) begin
            n_err++; $display("FAIL tmo_psel_drop: last=%b/%b next=%b, want 001000/1 000000",
                              o.psel_tr[1 + Tmo], o.pen_tr[1 + Tmo], o.psel_tr[2 + Tmo]); end
        n_chk++; if (irq_cnt - irq0 !== 1 || irq_run_max !== 1) begin
            n_err++; $display("FAIL tmo_irq: pulses=%0d width=%0d, want 1 1", irq_cnt - irq0,
                              irq_run_max); end
        n_chk++; if (err_addr_o !== 32'h2000_7000) begin
            n_err++; $display("FAIL tmo_err_addr: got %h, want 20007000", err_addr_o); end
        stall[3] = 1'b0;
    endtask

    task automatic test_disabled_port();
        obs_t o; exp_t e;
        sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
        apb_do(32'h2000_4000, 1'b0, 32'h0, o);
        e = sb.pop_front();
        n_chk++; if (!o.done || o.lat !== e.lat || o.err !== e.err || o.psel_or !== '0) begin
            n_err++; $display("FAIL disabled_port: lat=%0d err=%b psel=%b, want %0d %b 000000", o.lat,
                              o.err, o.psel_or, e.lat, e.err); end
        n_chk++; if (err_addr_o !== 32'h2000_4000) begin
            n_err++; $display("FAIL disabled_err_addr: got %h, want 20004000", err_addr_o); end
    endtask

    task automatic test_upstream_abort();
        obs_t o; exp_t e;
        bus.s_paddr_i = 32'h2000_0000; bus.s_pwrite_i = 1'b0;
        bus.s_psel_i = 1'b1; bus.s_penable_i = 1'b0;
        @(posedge clk_i); #1;
        bus.s_psel_i = 1'b0;
        @(negedge clk_i);
        n_chk++; if (bus.s_pready_o !== 1'b0 || bus.s_pslverr_o !== 1'b0) begin
            n_err++; $display("FAIL abort_discard: pready=%b pslverr=%b, want 0 0", bus.s_pready_o,
                              bus.s_pslverr_o); end
        @(posedge clk_i); #1;
        rd[0] = 32'h0000_AB00;
        sb.push_back('{rdata: 32'h0000_AB00, err: 1'b0, lat: 3});
        apb_do(32'h2000_1000, 1'b0, 32'h0, o);
        e = sb.pop_front();
        n_chk++; if (!o.done || o.lat !== e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
            n_err++; $display("FAIL abort_recover: lat=%0d rdata=%h err=%b, want %0d %h %b", o.lat,
                              o.rdata, o.err, e.lat, e.rdata, e.err); end
    endtask

    task automatic test_back_to_back();
        obs_t o1; obs_t o2; exp_t e;
        sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 3});
        sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 3});
        apb_do(32'h2000_1100, 1'b1, 32'h1111_1111, o1);
        n_chk++; if (bus.s_pready_o !== 1'b0 || bus.m_psel_o !== '0) begin
            n_err++; $display("FAIL b2b_idle: pready=%b psel=%b, want 0 000000", bus.s_pready_o,
                              bus.m_psel_o); end
        apb_do(32'h2000_5100, 1'b1, 32'h2222_2222, o2);
        e = sb.pop_front();
        n_chk++; if (!o1.done || o1.lat !== e.lat || o1.err !== e.err) begin
            n_err++; $display("FAIL b2b_first: lat=%0d err=%b, want %0d %b", o1.lat, o1.err, e.lat,
                              e.err); end
        e = sb.pop_front();
        n_chk++; if (!o2.done || o2.lat !== e.lat || o2.err !== e.err || o2.psel_tr[1] !== 6'b000100)
        begin
            n_err++; $display("FAIL b2b_second: lat=%0d err=%b psel=%b, want %0d %b 000100", o2.lat,
                              o2.err, o2.psel_tr[1], e.lat, e.err); end
        n_chk++; if (o2.resp_cyc - o1.resp_cyc !== 4) begin
            n_err++; $display("FAIL b2b_spacing: %0d cycles between responses, want 4",
                              o2.resp_cyc - o1.resp_cyc); end
    endtask

    task automatic test_reset_mid_access();
        obs_t o; exp_t e;
        stall[4] = 1'b1;
        bus.s_paddr_i = 32'h2000_8000; bus.s_pwrite_i = 1'b0;
        bus.s_psel_i = 1'b1; bus.s_penable_i = 1'b0;
        @(posedge clk_i); #1;
        bus.s_penable_i = 1'b1;
        repeat (2) begin @(posedge clk_i); #1; end
        @(negedge clk_i);
        n_chk++; if (bus.m_psel_o !== 6'b010000 || bus.m_penable_o !== 1'b1) begin
            n_err++; $display("FAIL rst_pre: psel=%b pen=%b, want 010000 1", bus.m_psel_o,
                              bus.m_penable_o); end
        #1 rst_ni = 1'b0;
        #1;
        n_chk++; if (bus.m_psel_o !== '0 || bus.m_penable_o !== 1'b0 || bus.m_paddr_o !== 32'h0) begin
            n_err++; $display("FAIL rst_async_m: psel=%b pen=%b paddr=%h, want 0", bus.m_psel_o,
                              bus.m_penable_o, bus.m_paddr_o); end
        n_chk++; if (bus.s_pready_o !== 1'b0 || err_addr_o !== 32'h0 || timeout_irq_o !== 1'b0) begin
            n_err++; $display("FAIL rst_async_s: pready=%b err_addr=%h irq=%b, want 0",
                              bus.s_pready_o, err_addr_o, timeout_irq_o); end
        bus.s_psel_i = 1'b0; bus.s_penable_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        stall[4] = 1'b0;
        sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 3});
        apb_do(32'h2000_8000, 1'b1, 32'h4444_4444, o);
        e = sb.pop_front();
        n_chk++; if (!o.done || o.lat !== e.lat || o.err !== e.err || o.psel_tr[1] !== 6'b010000) begin
            n_err++; $display("FAIL rst_after_wr: lat=%0d err=%b psel=%b, want %0d %b 010000", o.lat,
                              o.err, o.psel_tr[1], e.lat, e.err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NumSlv; i++) begin
            ws[i] = 0;
            rd[i] = 32'hDEAD_0000 | 32'(i);
        end
        stall = '0;
        serr  = '0;
        bus.s_paddr_i   = '0;
        bus.s_psel_i    = 1'b0;
        bus.s_penable_i = 1'b0;
        bus.s_pwrite_i  = 1'b0;
        bus.s_pwdata_i  = '0;
        bus.s_pstrb_i   = '0;
        bus.s_pprot_i   = '0;

        test_reset();
        test_write_hit();
        test_read_wait();
        test_miss();
        test_decode_boundary();
        test_slverr();
        test_timeout();
        test_disabled_port();
        test_upstream_abort();
        test_back_to_back();
        test_reset_mid_access();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/carfield_apb_periph_demux.md
CARFIELD_APB_PERIPH_DEMUX -- requirements
Module: carfield_apb_periph_demux

Interface
REQ-001 SHALL provide parameter NumSlv, default 6, number of APB completers (CAN, timer, advanced timer, watchdog, HyperBus cfg, streamer APB).
REQ-002 SHALL provide parameter SlvBase[NumSlv], default {'h20001000,'h20004000,'h20005000,'h20007000,'h20008000,'h20011000}, region base per port.
REQ-003 SHALL provide parameter SlvSize[NumSlv], default {'h1000,'h1000,'h1000,'h1000,'h1000,'h8000}, region size per port; 0 disables the port.
REQ-004 SHALL provide parameter TimeoutCycles, default 256, maximum ACCESS wait before abort (range 1..65535).
REQ-005 clk_i  in  1  single clock; all logic rising-edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 s_paddr_i in 32, s_psel_i in 1, s_penable_i in 1, s_pwrite_i in 1, s_pwdata_i in 32, s_pstrb_i in 4, s_pprot_i in 3: upstream APB request.
REQ-008 s_prdata_o out 32, s_pready_o out 1, s_pslverr_o out 1: upstream APB response.
REQ-009 m_psel_o out NumSlv, one-hot select; m_paddr_o 32, m_penable_o 1, m_pwrite_o 1, m_pwdata_o 32, m_pstrb_o 4, m_pprot_o 3: shared downstream request, all out.
REQ-010 m_prdata_i in NumSlv x 32, m_pready_i in NumSlv, m_pslverr_i in NumSlv: per-port downstream response.
REQ-011 timeout_irq_o out 1, one-cycle pulse on timeout; err_addr_o out 32, address of the last errored transfer.

Function
REQ-012 FSM states SHALL be IDLE, M_SETUP, M_ACCESS, RESP.
REQ-013 In IDLE, s_psel_i=1 and s_penable_i=0 SHALL register paddr/pwrite/pwdata/pstrb/pprot and the decode result.
REQ-014 Hit: SlvSize[i]!=0 and SlvBase[i] <= addr < SlvBase[i]+SlvSize[i], sum evaluated 33-bit (no wrap); lowest index SHALL win on overlap.
REQ-015 Hit SHALL go to M_SETUP; miss SHALL go to RESP with error flag set, no m_psel_o asserted.
REQ-016 M_SETUP SHALL drive m_psel_o[idx]=1, m_penable_o=0 for exactly one cycle, then M_ACCESS.
REQ-017 M_ACCESS SHALL drive m_psel_o[idx]=1, m_penable_o=1; on m_pready_i[idx]=1 SHALL capture m_prdata_i[idx] and m_pslverr_i[idx] and go to RESP.
REQ-018 M_ACCESS SHALL count cycles from 0; when count reaches TimeoutCycles-1 without pready, SHALL drop m_psel_o, set error, pulse timeout_irq_o next cycle, go to RESP.
REQ-019 RESP SHALL drive s_pready_o=1 for one cycle with captured s_prdata_o/s_pslverr_o, then IDLE; s_prdata_o=0 on miss, timeout and writes.
REQ-020 Any error (miss, timeout, downstream pslverr) SHALL load err_addr_o with the captured address in the RESP cycle.
REQ-021 Latency: hit with zero wait states SHALL assert s_pready_o 3 cycles after the setup cycle; miss SHALL assert it 1 cycle after.
REQ-022 m_paddr_o/m_pwrite_o/m_pwdata_o/m_pstrb_o/m_pprot_o SHALL hold captured values stable through M_SETUP and M_ACCESS.
REQ-023 s_pready_o SHALL be 0 in all states except RESP; m_psel_o SHALL be zero outside M_SETUP/M_ACCESS.
REQ-024 If s_psel_i is 0 in RESP (upstream protocol violation), the response SHALL be discarded (s_pready_o=0) and FSM returns to IDLE.
REQ-025 A new setup phase SHALL be accepted only in IDLE; back-to-back transfers incur one IDLE cycle.

Reset
REQ-026 Reset SHALL force IDLE, counter 0, and all outputs 0 (including err_addr_o), at any point including mid-access, with no further downstream strobes.
REQ-027 First transfer after reset release SHALL be accepted normally.

Verification
REQ-028 Write 'hA5A5A5A5 to 'h20001010, m_pready_i[0] tied 1 -> m_psel_o='b000001 cycle 1, m_penable_o cycle 2, s_pready_o cycle 3, s_pslverr_o=0.
REQ-029 Read 'h20018FFC, port 5 3 wait states returning 'h12345678 -> s_prdata_o='h12345678 at cycle 6; read 'h20019000 -> miss, s_pslverr_o=1 cycle 1, m_psel_o=0 throughout.
REQ-030 TimeoutCycles=16, read 'h20007000 with m_pready_i[3]=0 -> m_psel_o drops after 16 ACCESS cycles, timeout_irq_o one-cycle pulse, s_pslverr_o=1, err_addr_o='h20007000.
REQ-031 Port 2 returns m_pslverr_i=1 -> s_pslverr_o=1, err_addr_o updated, timeout_irq_o=0.
REQ-032 Assert rst_ni low during M_ACCESS to port 4 -> all outputs 0 asynchronously; next write to 'h20008000 completes in 3 cycles.
REQ-033 SlvSize[1]=0, access 'h20004000 -> miss error; two back-to-back hits -> second setup accepted only after IDLE cycle.
